// File: rtl/avalon_mem_tester.sv
// Wide-side Avalon-MM self-test master: writes a seeded pattern,
// reads it back one word at a time and reports mismatches/timeouts.
module avalon_mem_tester #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 12,
  parameter int WORD_CNT = 256,
  parameter int TIMEOUT  = 1024,
  localparam int BE_W    = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [31:0]       seed_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [31:0]       err_cnt_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic [ADDR_W-1:0] address_o,
  output logic [DATA_W-1:0] writedata_o,
  output logic [BE_W-1:0]   byteenable_o,
  output logic              write_o,
  output logic              read_o,
  input  logic [DATA_W-1:0] readdata_i,
  input  logic              readdatavalid_i,
  input  logic              waitrequest_i
);

  localparam int LANES = DATA_W / 32;
  localparam int CNT_W = (WORD_CNT > 1) ? $clog2(WORD_CNT) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RCMD,
    S_RWAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       seed_q, seed_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [31:0]       err_q, err_d;
  logic [ADDR_W-1:0] ferr_q, ferr_d;
  logic              tflag_q, tflag_d;

  logic [ADDR_W-1:0] addr_w;
  logic [DATA_W-1:0] pat;
  logic              last;
  logic              cmd;
  logic              rvalid_hit;
  logic              mismatch;
  logic [31:0]       err_inc;

  assign addr_w = base_q + ADDR_W'(idx_q) * ADDR_W'(BE_W);
  assign last   = (idx_q == CNT_W'(WORD_CNT - 1));

  always_comb begin
    pat = '0;
    for (int k = 0; k < LANES; k++) begin
      pat[32*k +: 32] = seed_q + 32'(idx_q) * 32'(LANES) + 32'(k);
    end
  end

  // Zero-latency slaves may return data in the accept cycle itself.
  assign rvalid_hit = readdatavalid_i &&
                      (state_q == S_RWAIT ||
                       (state_q == S_RCMD && !waitrequest_i));
  assign mismatch = (readdata_i != pat);
  assign err_inc  = (err_q == 32'hFFFF_FFFF) ? err_q : err_q + 32'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    seed_d  = seed_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    tflag_d = tflag_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          base_d  = base_addr_i;
          seed_d  = seed_i;
          err_d   = '0;
          ferr_d  = '0;
          tflag_d = 1'b0;
          idx_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!waitrequest_i) begin
          if (last) begin
            idx_d   = '0;
            state_d = S_RCMD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_RCMD: begin
        if (!waitrequest_i) begin
          tmo_d   = '0;
          state_d = S_RWAIT;
        end
      end
      S_RWAIT: begin
        if (!readdatavalid_i) begin
          if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            tflag_d = 1'b1;
            state_d = S_DONE;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rvalid_hit) begin
      if (mismatch) begin
        err_d = err_inc;
        if (err_q == 32'd0) ferr_d = addr_w;
      end
      if (last) begin
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = S_RCMD;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      seed_q  <= '0;
      tmo_q   <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      tflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      seed_q  <= seed_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      tflag_q <= tflag_d;
    end
  end

  assign write_o = (state_q == S_WRITE);
  assign read_o  = (state_q == S_RCMD);
  assign cmd     = write_o | read_o;

  // Bus fields are zeroed between commands so reset/idle is all-zero.
  assign address_o    = cmd ? addr_w : '0;
  assign writedata_o  = write_o ? pat : '0;
  assign byteenable_o = cmd ? '1 : '0;

  assign busy_o           = write_o | read_o | (state_q == S_RWAIT);
  assign done_o           = (state_q == S_DONE);
  assign pass_o           = done_o && (err_q == 32'd0) && !tflag_q;
  assign timeout_o        = tflag_q;
  assign err_cnt_o        = err_q;
  assign first_err_addr_o = ferr_q;

endmodule
